// File: rtl/ofdm_rx_cp_remove_pkg.sv
// Shared types for the OFDM receive CP-removal block: FSM state encoding and
// the {Q,I} sample layout used by the ADC chain.
// Latency/backpressure: not applicable (declarations only).
package ofdm_rx_pkg;

  localparam int IQ_W  = 16;
  localparam int I_LSB = 0;
  localparam int Q_LSB = 16;

  // IDLE must stay at zero: status[19:17] reads back as 0 out of reset.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OFFSET = 3'd1,
    CP     = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4
  } cp_state_t;

  // Build a packed {Q,I} sample from its two components.
  function automatic logic [2*IQ_W-1:0] iq_pack(input logic [IQ_W-1:0] i,
                                                input logic [IQ_W-1:0] q);
    logic [2*IQ_W-1:0] w;
    w = '0;
    w[I_LSB +: IQ_W] = i;
    w[Q_LSB +: IQ_W] = q;
    return w;
  endfunction

endpackage

// File: rtl/ofdm_rx_cp_remove_if.sv
// AXI-stream style bundle (tdata/tvalid/tready/tlast/tuser) for sample streams.
// Latency: none, wires only.
// Backpressure: tready flows from slave to master; master holds tvalid/tdata until accepted.
interface ofdm_rx_cp_remove_if import ofdm_rx_pkg::*; #(
  parameter int DATA_W = 2*IQ_W
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/ofdm_rx_cp_remove_reg_slice.sv
// One-deep output register slice carrying data plus last/user sideband.
// Latency: 1 cycle from accepted input to out_vld.
// Backpressure: in_rdy = ~out_vld | out_rdy, so full throughput; contents held while stalled.
// Ports: aclk/aresetn; in_* upstream handshake; out_* downstream handshake.
module axis_reg_slice import ofdm_rx_pkg::*; #(
  parameter int DATA_W = 2*IQ_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_last,
  input  logic              in_user,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_last,
  output logic              out_user,
  output logic              out_vld,
  input  logic              out_rdy
);

  assign in_rdy = ~out_vld | out_rdy;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_last <= 1'b0;
      out_user <= 1'b0;
    end else if (in_vld && in_rdy) begin
      out_vld  <= 1'b1;
      out_dat  <= in_dat;
      out_last <= in_last;
      out_user <= in_user;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/ofdm_rx_cp_remove.sv
// OFDM RX cyclic-prefix removal: after start, drop timing_offset samples, then per symbol
//   drop cp_len samples and forward fft_len payload samples (tuser first, tlast last).
// Latency: 1 cycle (accepted payload beat appears on m_axis the next cycle).
// Backpressure: s_axis.tready=1 outside DATA (samples dropped); in DATA follows the output slice.
// Ports: aclk, aresetn (async active-low); start/stop pulses; timing_offset, cp_len, fft_len,
//   num_symbols (latched on start, 0 symbols = continuous); s_axis in, m_axis out; busy, done, status.
// Optional: define OFDM_RX_CP_STATUS_EN for the status word (symbol count, overflow flag, state);
//   otherwise status is tied to zero.
module ofdm_rx_cp_remove import ofdm_rx_pkg::*; #(
  parameter int DATA_W = 2*IQ_W,
  parameter int LEN_W  = 16,
  parameter int SYM_W  = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic               stop,
  input  logic [LEN_W-1:0]   timing_offset,
  input  logic [LEN_W-1:0]   cp_len,
  input  logic [LEN_W-1:0]   fft_len,
  input  logic [SYM_W-1:0]   num_symbols,
  ofdm_rx_cp_remove_if.slave  s_axis,
  ofdm_rx_cp_remove_if.master m_axis,
  output logic               busy,
  output logic               done,
  output logic [31:0]        status
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [SYM_W-1:0] SYM_ONE = SYM_W'(1);

  cp_state_t          state;
  logic [LEN_W-1:0]   off_q, cp_q, fft_q, beat_cnt;
  logic [SYM_W-1:0]   nsym_q, sym_cnt, sym_next;
  logic               slice_rdy, beat, fwd_vld, pay_first, pay_last, start_ok;
  logic               unused_s_axis;

  // Input sideband is meaningless here; framing is regenerated from the counters.
  assign unused_s_axis = s_axis.tlast ^ s_axis.tuser;

  assign s_axis.tready = (state == DATA) ? slice_rdy : 1'b1;
  assign beat          = s_axis.tvalid & s_axis.tready;
  // A beat taken in the stop cycle is consumed but not forwarded.
  assign fwd_vld       = (state == DATA) & s_axis.tvalid & ~stop;
  assign pay_first     = (beat_cnt == '0);
  assign pay_last      = (beat_cnt == fft_q - LEN_ONE);
  assign sym_next      = sym_cnt + SYM_ONE;
  assign start_ok      = (state == IDLE) & start & ~stop;

  axis_reg_slice #(.DATA_W(DATA_W)) u_out_slice (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .in_dat   (s_axis.tdata),
    .in_last  (pay_last),
    .in_user  (pay_first),
    .in_vld   (fwd_vld),
    .in_rdy   (slice_rdy),
    .out_dat  (m_axis.tdata),
    .out_last (m_axis.tlast),
    .out_user (m_axis.tuser),
    .out_vld  (m_axis.tvalid),
    .out_rdy  (m_axis.tready)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      off_q    <= '0;
      cp_q     <= '0;
      fft_q    <= '0;
      nsym_q   <= '0;
      beat_cnt <= '0;
      sym_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        busy     <= 1'b0;
        beat_cnt <= '0;
        sym_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              off_q    <= timing_offset;
              cp_q     <= cp_len;
              fft_q    <= fft_len;
              nsym_q   <= num_symbols;
              beat_cnt <= '0;
              sym_cnt  <= '0;
              busy     <= 1'b1;
              // Zero-length phases are skipped straight away.
              if (timing_offset != '0)  state <= OFFSET;
              else if (cp_len != '0)    state <= CP;
              else                      state <= DATA;
            end
          end
          OFFSET: begin
            if (beat) begin
              if (beat_cnt == off_q - LEN_ONE) begin
                beat_cnt <= '0;
                state    <= (cp_q != '0) ? CP : DATA;
              end else begin
                beat_cnt <= beat_cnt + LEN_ONE;
              end
            end
          end
          CP: begin
            if (beat) begin
              if (beat_cnt == cp_q - LEN_ONE) begin
                beat_cnt <= '0;
                state    <= DATA;
              end else begin
                beat_cnt <= beat_cnt + LEN_ONE;
              end
            end
          end
          DATA: begin
            if (beat) begin
              if (pay_last) begin
                beat_cnt <= '0;
                sym_cnt  <= sym_next;   // wraps naturally in continuous mode
                if ((nsym_q != '0) && (sym_next == nsym_q)) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state <= (cp_q != '0) ? CP : DATA;
                end
              end else begin
                beat_cnt <= beat_cnt + LEN_ONE;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef OFDM_RX_CP_STATUS_EN
  logic [15:0] sym_emitted;
  logic        ovf_flag;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sym_emitted <= '0;
      ovf_flag    <= 1'b0;
    end else if (start_ok) begin
      sym_emitted <= '0;
      ovf_flag    <= 1'b0;
    end else begin
      if (s_axis.tvalid && !s_axis.tready) ovf_flag <= 1'b1;
      if (fwd_vld && slice_rdy && pay_last && (sym_emitted != 16'hFFFF))
        sym_emitted <= sym_emitted + 16'd1;
    end
  end

  assign status = {12'h000, state, ovf_flag, sym_emitted};
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign status = 32'h0;
`endif

endmodule

// File: tb/tb_ofdm_rx_cp_remove.sv
// Self-checking bench for ofdm_rx_cp_remove: a per-cycle reference model computes, from each
// accepted input beat index, whether it is offset/CP/payload, and predicts the output register,
// tready, busy, done and status; directed scenarios add literal expectations on top.
module tb_ofdm_rx_cp_remove;
  import ofdm_rx_pkg::*;

  logic        aclk, aresetn, start, stop;
  logic [15:0] timing_offset, cp_len, fft_len, num_symbols;
  logic        busy, done;
  logic [31:0] status;

  ofdm_rx_cp_remove_if #(.DATA_W(32)) s_axis ();
  ofdm_rx_cp_remove_if #(.DATA_W(32)) m_axis ();

  ofdm_rx_cp_remove #(.DATA_W(32), .LEN_W(16), .SYM_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .timing_offset(timing_offset), .cp_len(cp_len), .fft_len(fft_len),
    .num_symbols(num_symbols), .s_axis(s_axis), .m_axis(m_axis),
    .busy(busy), .done(done), .status(status)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int v);
    logic [15:0] t;
    t = v[15:0];
    return iq_pack(t, ~t);
  endfunction

  // ---------------- reference model ----------------
  int          phase;          // 0 idle, 1 framing, 2 done cycle
  int          kb;             // accepted beats since start
  int          m_off, m_cp, m_fft, m_nsym, m_syms;
  bit          m_ovf, ovld, olast, ouser;
  logic [31:0] odat;
  bit          s_taken;
  int          done_cnt;
  logic [31:0] got_d[$];
  bit          got_l[$], got_u[$];

  function automatic void classify(input int k, output bit pay, output int idx, output int sym);
    int p, per;
    pay = 0; idx = 0; sym = 0;
    if (k < m_off) return;
    p   = k - m_off;
    per = m_cp + m_fft;
    sym = p / per;
    idx = (p % per) - m_cp;
    pay = (p % per) >= m_cp;
  endfunction

  always @(negedge aclk) begin : cmp
    bit pay, exp_rdy, beat, loaded;
    int idx, sym;
    if (!aresetn) begin
      phase = 0; kb = 0; ovld = 0; olast = 0; ouser = 0; odat = '0;
      m_syms = 0; m_ovf = 0; s_taken = 0;
    end else begin
      classify(kb, pay, idx, sym);
      exp_rdy = (phase == 1 && pay) ? (!ovld || m_axis.tready) : 1'b1;
      chk("s_tready", s_axis.tready, exp_rdy);
      chk("m_tvalid", m_axis.tvalid, ovld);
      if (ovld) begin
        chk("m_tdata", m_axis.tdata, odat);
        chk("m_tlast", m_axis.tlast, olast);
        chk("m_tuser", m_axis.tuser, ouser);
      end
      chk("busy", busy, phase != 0);
      chk("done", done, phase == 2);
`ifdef OFDM_RX_CP_STATUS_EN
      chk("status_lo", status[16:0], {m_ovf, m_syms[15:0]});
      chk("status_hi", status[31:20], 0);
`else
      chk("status", status, 0);
`endif
      s_taken = s_axis.tvalid && s_axis.tready;
      if (m_axis.tvalid && m_axis.tready) begin
        got_d.push_back(m_axis.tdata);
        got_l.push_back(m_axis.tlast);
        got_u.push_back(m_axis.tuser);
      end
      if (done) done_cnt++;

      beat   = s_axis.tvalid && exp_rdy;
      loaded = 0;
      if (s_axis.tvalid && !exp_rdy) m_ovf = 1;
      if (stop) phase = 0;
      else if (phase == 0) begin
        if (start) begin
          phase = 1; kb = 0; m_syms = 0; m_ovf = 0;
          m_off = timing_offset; m_cp = cp_len; m_fft = fft_len; m_nsym = num_symbols;
        end
      end else if (phase == 2) phase = 0;
      else if (beat) begin
        if (pay) begin
          loaded = 1;
          odat   = s_axis.tdata;
          olast  = (idx == m_fft - 1);
          ouser  = (idx == 0);
          if (idx == m_fft - 1) begin
            if (m_syms < 65535) m_syms++;
            if (m_nsym != 0 && sym == m_nsym - 1) phase = 2;
          end
        end
        kb++;
      end
      if (loaded) ovld = 1;
      else if (m_axis.tready) ovld = 0;
    end
  end

  // ---------------- stimulus ----------------
  int ramp = 0;
  bit tog  = 0;

  task automatic next_cycle();
    @(posedge aclk);
    #1;
    if (s_taken) ramp++;
    s_axis.tdata = pk(ramp);
    start = 1'b0;
    stop  = 1'b0;
    tog   = ~tog;
  endtask

  // vmode: 0 idle, 1 always valid, 2 random; rmode: 0 ready, 1 toggling, 2 random, 3 stalled
  task automatic run(input int n, input int vmode, input int rmode);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      s_axis.tvalid = (vmode == 1) ? 1'b1 :
                      (vmode == 2) ? ($urandom_range(0, 99) < 75) : 1'b0;
      m_axis.tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog :
                      (rmode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  endtask

  task automatic pulse_start(input int off, input int cp, input int fft, input int ns);
    next_cycle();
    timing_offset = off[15:0]; cp_len = cp[15:0]; fft_len = fft[15:0]; num_symbols = ns[15:0];
    start = 1'b1;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    ramp = 0;
    s_axis.tdata = pk(ramp);
    got_d.delete(); got_l.delete(); got_u.delete();
    done_cnt = 0;
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; stop = 1'b0;
    timing_offset = '0; cp_len = '0; fft_len = 16'd1; num_symbols = '0;
    s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
    m_axis.tready = 1'b1;
    done_cnt = 0;
    #12;
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_tuser", m_axis.tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    @(posedge aclk); #1 aresetn = 1'b1;
    run(3, 0, 0);

    // 1: basic framing with a ramp input
    pulse_start(5, 4, 8, 2);
    run(40, 1, 0);
    chk("t1_count", got_d.size(), 16);
    if (got_d.size() >= 16) begin
      chk("t1_first", got_d[0], pk(9));
      chk("t1_first_user", got_u[0], 1);
      chk("t1_sym0_last", got_d[7], pk(16));
      chk("t1_sym0_tlast", got_l[7], 1);
      chk("t1_sym1_first", got_d[8], pk(21));
      chk("t1_sym1_user", got_u[8], 1);
      chk("t1_sym1_last", got_d[15], pk(28));
    end
    chk("t1_done_pulses", done_cnt, 1);
    @(negedge aclk);
    chk("t1_idle", busy, 0);

    // 2: same framing under 1010 output backpressure
    pulse_start(5, 4, 8, 2);
    run(90, 1, 1);
    run(4, 0, 0);
    chk("t2_count", got_d.size(), 16);
    if (got_d.size() >= 16) begin
      chk("t2_first", got_d[0], pk(9));
      chk("t2_mid", got_d[8], pk(21));
      chk("t2_last", got_d[15], pk(28));
    end
    chk("t2_done_pulses", done_cnt, 1);

    // 3: no offset, no CP, single-sample symbols
    pulse_start(0, 0, 1, 3);
    run(10, 1, 0);
    chk("t3_count", got_d.size(), 3);
    if (got_d.size() >= 3) begin
      chk("t3_d0", got_d[0], pk(0));
      chk("t3_d2", got_d[2], pk(2));
      chk("t3_user1", got_u[1], 1);
      chk("t3_last1", got_l[1], 1);
    end
    chk("t3_done_pulses", done_cnt, 1);

    // 4: continuous mode with random handshakes, then stop
    pulse_start(3, 4, 16, 0);
    run(600, 2, 2);
    next_cycle();
    stop = 1'b1;
    s_axis.tvalid = 1'b0;
    next_cycle();
    @(negedge aclk);
    chk("t4_stopped", busy, 0);
    chk("t4_ten_symbols", got_d.size() >= 160, 1);
    run(4, 0, 0);
    chk("t4_no_done", done_cnt, 0);

    // 5: start while busy carries a different cp_len and must be ignored
    pulse_start(2, 4, 8, 3);
    run(10, 1, 0);
    next_cycle();
    s_axis.tvalid = 1'b1;
    cp_len = 16'd7; timing_offset = 16'd9;
    start = 1'b1;
    run(50, 1, 0);
    chk("t5_count", got_d.size(), 24);
    if (got_d.size() >= 24) begin
      chk("t5_sym1", got_d[8], pk(18));
      chk("t5_sym2", got_d[16], pk(30));
    end
    chk("t5_done_pulses", done_cnt, 1);

    // 6: stall output while input keeps coming, then restart
    pulse_start(0, 1, 4, 0);
    run(20, 1, 0);
    run(10, 1, 3);
    @(negedge aclk);
`ifdef OFDM_RX_CP_STATUS_EN
    chk("t6_ovf_set", status[16], 1);
`else
    chk("t6_status_off", status, 0);
`endif
    next_cycle();
    stop = 1'b1;
    m_axis.tready = 1'b1;
    run(3, 0, 0);
    pulse_start(0, 1, 4, 0);
    run(12, 1, 0);
    @(negedge aclk);
`ifdef OFDM_RX_CP_STATUS_EN
    chk("t6_ovf_clear", status[16], 0);
    chk("t6_sym_count", status[15:0], 2);
`else
    chk("t6_status_off2", status, 0);
`endif
    next_cycle();
    stop = 1'b1;
    run(3, 0, 0);

    // 7: random configurations and handshakes, frames must complete
    for (int it = 0; it < 6; it++) begin
      bit idle;
      pulse_start($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 6),
                  $urandom_range(1, 3));
      idle = 0;
      for (int c = 0; c < 400 && !idle; c++) begin
        run(1, 2, 2);
        @(negedge aclk);
        idle = !busy;
      end
      chk("t7_frame_end", idle, 1);
      chk("t7_done_pulses", done_cnt, 1);
      run(4, 0, 0);
    end

    // 8: asynchronous reset in the middle of a frame
    pulse_start(2, 1, 4, 0);
    run(10, 1, 2);
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_tvalid", m_axis.tvalid, 0);
    chk("arst_tdata", m_axis.tdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_status", status, 0);
    @(posedge aclk); #1 aresetn = 1'b1;
    run(5, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
